// File: rtl/spi_cmd_sequencer.sv
// Command sequencer feeding the SPI master engine: TX command FIFO, one-at-a-time
// dispatch with a go/state handshake, and an RX FIFO collecting received bytes.
module spi_cmd_sequencer #(
    parameter int AW = 4
) (
    input  logic          rst,
    input  logic          clkin,
    input  logic [15:0]   cmd_data,
    input  logic          cmd_wr,
    output logic          cmd_full,
    output logic [AW:0]   cmd_level,
    output logic [7:0]    rd_data,
    input  logic          rd_req,
    output logic          rd_empty,
    output logic          busy,
    output logic          tx_ovf,
    output logic          rx_ovf,
    input  logic          clr_err,
    output logic          spi_go,
    output logic [15:0]   spi_data,
    input  logic          spi_state,
    input  logic [7:0]    spi_rx
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        CAPTURE
    } state_t;

    state_t      state, state_nxt;

    logic [15:0] tx_mem [DEPTH];
    logic [7:0]  rx_mem [DEPTH];
    logic [AW:0] tx_wptr, tx_rptr;
    logic [AW:0] rx_wptr, rx_rptr;
    logic        tx_empty, rx_full;
    logic        tx_push, rx_pop;
    logic        load, rx_push;
    logic [15:0] tx_head;
    logic [1:0]  wait_cnt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign tx_empty  = (tx_wptr == tx_rptr);
    assign cmd_full  = (tx_wptr[AW] != tx_rptr[AW]) &&
                       (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
    assign cmd_level = tx_wptr - tx_rptr;
    assign tx_head   = tx_mem[tx_rptr[AW-1:0]];

    assign rd_empty  = (rx_wptr == rx_rptr);
    assign rx_full   = (rx_wptr[AW] != rx_rptr[AW]) &&
                       (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
    assign rd_data   = rx_mem[rx_rptr[AW-1:0]];

    assign tx_push   = cmd_wr && !cmd_full;
    assign rx_pop    = rd_req && !rd_empty;

    assign spi_go    = (state == ISSUE);
    assign busy      = (state != IDLE) || !tx_empty;

    // NOTE: storage arrays have no reset; only pointers define FIFO contents,
    // so clearing the array would only cost reset fan-out.
    always_ff @(posedge clkin) begin
        if (tx_push)
            tx_mem[tx_wptr[AW-1:0]] <= cmd_data;
        if (rx_push)
            rx_mem[rx_wptr[AW-1:0]] <= spi_rx;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (tx_push)
                tx_wptr <= tx_wptr + 1'b1;
            if (load)
                tx_rptr <= tx_rptr + 1'b1;
            if (rx_push)
                rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)
                rx_rptr <= rx_rptr + 1'b1;
        end
    end

    // A set event in the same cycle as clr_err wins.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (cmd_wr && cmd_full)
                tx_ovf <= 1'b1;
            else if (clr_err)
                tx_ovf <= 1'b0;
            if (rd_req && rd_empty)
                rx_ovf <= 1'b1;
            else if (clr_err)
                rx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            spi_data <= 16'h0000;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == WAIT_BUSY) ? wait_cnt + 2'd1 : 2'd0;
            // spi_data is only written on load, so it holds through the transfer.
            if (load)
                spi_data <= tx_head;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        rx_push   = 1'b0;
        case (state)
            IDLE: begin
                // A data command waits for RX space rather than being dropped.
                if (!tx_empty && !spi_state && (tx_head[15] || !rx_full)) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:
                state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (spi_state)
                    state_nxt = WAIT_DONE;
                else if (wait_cnt == 2'd3)
                    state_nxt = IDLE;
            end
            WAIT_DONE: begin
                if (!spi_state)
                    state_nxt = CAPTURE;
            end
            CAPTURE: begin
                rx_push   = !spi_data[15] && !rx_full;
                state_nxt = IDLE;
            end
            default:
                state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer (AW=2) with a behavioural SPI engine.
module tb_spi_cmd_sequencer;

    localparam int AW = 2;

    logic          rst;
    logic          clkin;
    logic [15:0]   cmd_data = 16'h0000;
    logic          cmd_wr = 1'b0;
    logic          cmd_full;
    logic [AW:0]   cmd_level;
    logic [7:0]    rd_data;
    logic          rd_req = 1'b0;
    logic          rd_empty;
    logic          busy;
    logic          tx_ovf;
    logic          rx_ovf;
    logic          clr_err = 1'b0;
    logic          spi_go;
    logic [15:0]   spi_data;
    logic          spi_state = 1'b0;
    logic [7:0]    spi_rx = 8'h00;

    spi_cmd_sequencer #(.AW(AW)) dut (
        .rst       (rst),
        .clkin     (clkin),
        .cmd_data  (cmd_data),
        .cmd_wr    (cmd_wr),
        .cmd_full  (cmd_full),
        .cmd_level (cmd_level),
        .rd_data   (rd_data),
        .rd_req    (rd_req),
        .rd_empty  (rd_empty),
        .busy      (busy),
        .tx_ovf    (tx_ovf),
        .rx_ovf    (rx_ovf),
        .clr_err   (clr_err),
        .spi_go    (spi_go),
        .spi_data  (spi_data),
        .spi_state (spi_state),
        .spi_rx    (spi_rx)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    int n_checks = 0;
    int n_err    = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Default engine reply when no explicit reply is queued.
    function automatic logic [7:0] resp_of(input logic [15:0] w);
        return w[7:0] ^ 8'h5A ^ {4'h0, w[11:8]};
    endfunction

    typedef enum logic [1:0] {ENG_NORMAL, ENG_STALL, ENG_DEAD} eng_mode_t;
    eng_mode_t   eng_mode = ENG_NORMAL;
    int          eng_cnt = 0;
    logic [15:0] eng_data = 16'h0000;
    logic [7:0]  eng_resp = 8'h00;
    logic        eng_pending = 1'b0;
    logic        eng_stalled = 1'b0;
    logic        prev_go = 1'b0;
    int          go_count = 0;
    logic [15:0] go_log[$];
    logic [7:0]  resp_q[$];

    // Engine: registers go, stays busy for the bit count, then presents its byte.
    always @(negedge clkin) begin
        if (rst) begin
            spi_state   = 1'b0;
            eng_cnt     = 0;
            eng_pending = 1'b0;
            eng_stalled = 1'b0;
            prev_go     = 1'b0;
        end else begin
            if (spi_go) begin
                check("go_single_cycle", {31'd0, prev_go}, 32'd0);
                go_count++;
                go_log.push_back(spi_data);
            end
            if (eng_mode == ENG_STALL) begin
                spi_state   = 1'b1;
                eng_stalled = 1'b1;
                eng_cnt     = 0;
            end else if (spi_state) begin
                if (!eng_stalled)
                    check("spi_data_stable", {16'd0, spi_data}, {16'd0, eng_data});
                if (eng_cnt == 0) begin
                    spi_state   = 1'b0;
                    spi_rx      = eng_resp;
                    eng_stalled = 1'b0;
                end else begin
                    eng_cnt--;
                end
            end else if (eng_pending) begin
                spi_state   = 1'b1;
                eng_pending = 1'b0;
            end else if (spi_go && eng_mode == ENG_NORMAL) begin
                eng_data    = spi_data;
                eng_cnt     = spi_data[15] ? 1 : int'(spi_data[11:8]);
                if (!spi_data[15] && resp_q.size() > 0)
                    eng_resp = resp_q.pop_front();
                else
                    eng_resp = resp_of(spi_data);
                eng_pending = 1'b1;
            end
            prev_go = spi_go;
        end
    end

    task automatic push(input logic [15:0] w);
        cmd_data = w;
        cmd_wr   = 1'b1;
        @(negedge clkin);
        cmd_wr   = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [7:0] exp);
        check({name, "_nonempty"}, {31'd0, rd_empty}, 32'd0);
        check(name, {24'd0, rd_data}, {24'd0, exp});
        rd_req = 1'b1;
        @(negedge clkin);
        rd_req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy && !spi_state)
                break;
            @(negedge clkin);
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_go(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (spi_go)
                break;
            @(negedge clkin);
        end
        check(name, {31'd0, spi_go}, 32'd1);
    endtask

    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  resp;
        logic        exp_empty;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t        vecs[7];
    int          base;
    int          gbase;
    int          n_sent;
    int          cyc;
    int          n;
    logic [15:0] w;
    logic [15:0] sent[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  exp_tmp;

    initial begin
        vecs[0] = '{16'h0801, 8'h3C, 1'b0, 8'h3C};
        vecs[1] = '{16'h08A5, 8'hC3, 1'b0, 8'hC3};
        vecs[2] = '{16'h8000, 8'h00, 1'b1, 8'h00};
        vecs[3] = '{16'h0855, 8'hAA, 1'b0, 8'hAA};
        vecs[4] = '{16'h8001, 8'h00, 1'b1, 8'h00};
        vecs[5] = '{16'h0000, 8'h5E, 1'b0, 8'h5E};  // bit count 0 still captures
        vecs[6] = '{16'h0F7E, 8'h81, 1'b0, 8'h81};

        rst = 1'b1;
        repeat (3) @(negedge clkin);
        check("rst_spi_go",    {31'd0, spi_go},    32'd0);
        check("rst_spi_data",  {16'd0, spi_data},  32'd0);
        check("rst_tx_ovf",    {31'd0, tx_ovf},    32'd0);
        check("rst_rx_ovf",    {31'd0, rx_ovf},    32'd0);
        check("rst_cmd_full",  {31'd0, cmd_full},  32'd0);
        check("rst_cmd_level", {29'd0, cmd_level}, 32'd0);
        check("rst_rd_empty",  {31'd0, rd_empty},  32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        #2 rst = 1'b0;
        @(negedge clkin);

        // Table-driven single commands.
        for (int i = 0; i < 7; i++) begin
            if (!vecs[i].cmd[15])
                resp_q.push_back(vecs[i].resp);
            push(vecs[i].cmd);
            wait_go("vec_go", 20);
            check("vec_go_data", {16'd0, spi_data}, {16'd0, vecs[i].cmd});
            wait_idle("vec_idle", 100);
            check("vec_rd_empty", {31'd0, rd_empty}, {31'd0, vecs[i].exp_empty});
            if (!vecs[i].exp_empty)
                read_check("vec_rd_data", vecs[i].exp_rd);
        end
        check("vec_go_total", go_count, 7);

        // Two queued data commands.
        base = go_count;
        resp_q.push_back(8'h3C);
        resp_q.push_back(8'hC3);
        push(16'h0801);
        push(16'h08A5);
        wait_idle("pair_idle", 200);
        check("pair_go_count", go_count - base, 2);
        read_check("pair_rd0", 8'h3C);
        read_check("pair_rd1", 8'hC3);
        check("pair_rd_empty", {31'd0, rd_empty}, 32'd1);
        check("pair_busy", {31'd0, busy}, 32'd0);

        // CS / data / CS mix: one RX entry, issue order preserved.
        base = go_count;
        gbase = go_log.size();
        resp_q.push_back(8'h96);
        push(16'h8000);
        push(16'h0855);
        push(16'h8001);
        wait_idle("mix_idle", 200);
        check("mix_go_count", go_count - base, 3);
        check("mix_go0", {16'd0, go_log[gbase]},     32'h8000);
        check("mix_go1", {16'd0, go_log[gbase + 1]}, 32'h0855);
        check("mix_go2", {16'd0, go_log[gbase + 2]}, 32'h8001);
        read_check("mix_rd", 8'h96);
        check("mix_rd_empty", {31'd0, rd_empty}, 32'd1);

        // Underflow flag; set beats a simultaneous clear.
        rd_req = 1'b1;
        @(negedge clkin);
        check("rx_ovf_set", {31'd0, rx_ovf}, 32'd1);
        clr_err = 1'b1;
        @(negedge clkin);
        check("rx_ovf_set_wins", {31'd0, rx_ovf}, 32'd1);
        rd_req = 1'b0;
        @(negedge clkin);
        clr_err = 1'b0;
        check("rx_ovf_clear", {31'd0, rx_ovf}, 32'd0);

        // TX overflow with the engine stalled busy.
        base = go_count;
        eng_mode = ENG_STALL;
        repeat (2) @(negedge clkin);
        push(16'h8000);
        push(16'h8001);
        push(16'h8000);
        check("txf_not_full3", {31'd0, cmd_full}, 32'd0);
        push(16'h8001);
        check("txf_full", {31'd0, cmd_full}, 32'd1);
        check("txf_level4", {29'd0, cmd_level}, 32'd4);
        check("txf_no_ovf", {31'd0, tx_ovf}, 32'd0);
        check("txf_busy", {31'd0, busy}, 32'd1);
        push(16'h0899);
        check("txf_ovf", {31'd0, tx_ovf}, 32'd1);
        check("txf_level_kept", {29'd0, cmd_level}, 32'd4);
        clr_err = 1'b1;
        @(negedge clkin);
        clr_err = 1'b0;
        check("txf_ovf_cleared", {31'd0, tx_ovf}, 32'd0);
        eng_mode = ENG_NORMAL;
        wait_idle("txf_idle", 300);
        check("txf_go_count", go_count - base, 4);
        check("txf_rd_empty", {31'd0, rd_empty}, 32'd1);

        // RX full stalls the next data command until a read frees a slot.
        base = go_count;
        for (int i = 0; i < 4; i++)
            push(16'h0810 + 16'(i));
        wait_idle("rxf_idle", 300);
        check("rxf_go4", go_count - base, 4);
        push(16'h0877);
        repeat (20) @(negedge clkin);
        check("rxf_stalled_go", go_count - base, 4);
        check("rxf_level1", {29'd0, cmd_level}, 32'd1);
        check("rxf_busy", {31'd0, busy}, 32'd1);
        read_check("rxf_rd0", resp_of(16'h0810));
        wait_idle("rxf_idle2", 100);
        check("rxf_go5", go_count - base, 5);
        for (int i = 1; i < 4; i++)
            read_check("rxf_rd", resp_of(16'h0810 + 16'(i)));
        read_check("rxf_rd_last", resp_of(16'h0877));
        check("rxf_rd_empty", {31'd0, rd_empty}, 32'd1);

        // Engine never answers: ISSUE plus four WAIT_BUSY cycles, then IDLE.
        eng_mode = ENG_DEAD;
        push(16'h0812);
        wait_go("dead_go", 20);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clkin);
            n = i;
            if (!busy)
                break;
        end
        check("dead_cycles_to_idle", n, 5);
        check("dead_no_rx", {31'd0, rd_empty}, 32'd1);
        eng_mode = ENG_NORMAL;
        resp_q.push_back(8'h4D);
        push(16'h0833);
        wait_idle("dead_next_idle", 100);
        read_check("dead_next_rd", 8'h4D);

        // Async reset while waiting for the transfer to finish.
        rd_req = 1'b1;
        @(negedge clkin);
        rd_req = 1'b0;
        check("rstw_rx_ovf_pre", {31'd0, rx_ovf}, 32'd1);
        push(16'h0F12);
        push(16'h8001);
        wait_go("rstw_go", 20);
        for (int i = 0; i < 10; i++) begin
            if (spi_state)
                break;
            @(negedge clkin);
        end
        @(negedge clkin);
        check("rstw_level_pre", {29'd0, cmd_level}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstw_spi_go",    {31'd0, spi_go},    32'd0);
        check("rstw_cmd_level", {29'd0, cmd_level}, 32'd0);
        check("rstw_rd_empty",  {31'd0, rd_empty},  32'd1);
        check("rstw_rx_ovf",    {31'd0, rx_ovf},    32'd0);
        check("rstw_tx_ovf",    {31'd0, tx_ovf},    32'd0);
        check("rstw_busy",      {31'd0, busy},      32'd0);
        check("rstw_spi_data",  {16'd0, spi_data},  32'd0);
        @(negedge clkin);
        @(negedge clkin);
        #2 rst = 1'b0;
        @(negedge clkin);
        resp_q.delete();

        // Random traffic against a transaction-level model.
        go_log.delete();
        n_sent = 0;
        cyc    = 0;
        while ((n_sent < 40 || busy || exp_rx.size() != 0) && cyc < 4000) begin
            if (!rd_empty && $urandom_range(0, 2) == 0) begin
                if (exp_rx.size() == 0) begin
                    check("rand_rx_extra", {31'd0, rd_empty}, 32'd1);
                    rd_req = 1'b0;
                end else begin
                    exp_tmp = exp_rx.pop_front();
                    check("rand_rd_data", {24'd0, rd_data}, {24'd0, exp_tmp});
                    rd_req = 1'b1;
                end
            end else begin
                rd_req = 1'b0;
            end
            if (n_sent < 40 && !cmd_full && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 3) == 0)
                    w = {1'b1, 14'h0000, 1'($urandom_range(0, 1))};
                else
                    w = {4'h0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
                cmd_data = w;
                cmd_wr   = 1'b1;
                sent.push_back(w);
                if (!w[15])
                    exp_rx.push_back(resp_of(w));
                n_sent++;
            end else begin
                cmd_wr = 1'b0;
            end
            @(negedge clkin);
            cyc++;
        end
        rd_req = 1'b0;
        cmd_wr = 1'b0;
        @(negedge clkin);
        check("rand_finished", {31'd0, cyc < 4000}, 32'd1);
        check("rand_go_total", go_log.size(), sent.size());
        for (int i = 0; i < sent.size() && i < go_log.size(); i++)
            check("rand_go_order", {16'd0, go_log[i]}, {16'd0, sent[i]});
        check("rand_rd_empty", {31'd0, rd_empty}, 32'd1);
        check("rand_tx_ovf", {31'd0, tx_ovf}, 32'd0);
        check("rand_rx_ovf", {31'd0, rx_ovf}, 32'd0);
        check("rand_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
- Upstream feeder for the SPI master engine.
- Buffers 16-bit command words from the host/bus side in a TX FIFO and dispatches them one at a time to the engine with a go/state handshake.
- Holds each command word stable for the whole transfer.
- Captures each received byte into an RX FIFO for host readback.
- CS commands (bit 15 set) produce no RX entry.

Parameters:
- AW, 4, log2 of FIFO depth; both TX and RX FIFOs hold 2^AW entries.

Ports:
- rst  in  1  asynchronous, active-high reset
- clkin  in  1  clock; same clock as the SPI engine
- cmd_data  in  16  command word; bit15=1: CS command (bit0 = CS level); bit15=0: bits[11:8] bit count, bits[7:0] TX data
- cmd_wr  in  1  push cmd_data into TX FIFO; ignored when cmd_full
- cmd_full  out  1  TX FIFO full
- cmd_level  out  AW+1  TX FIFO occupancy
- rd_data  out  8  RX FIFO head, first-word fall-through; valid when !rd_empty
- rd_req  in  1  pop RX FIFO head; ignored when rd_empty
- rd_empty  out  1  RX FIFO empty
- busy  out  1  high when the FSM is not IDLE or the TX FIFO is non-empty
- tx_ovf  out  1  sticky; set on cmd_wr while cmd_full
- rx_ovf  out  1  sticky; set on rd_req while rd_empty (underflow)
- clr_err  in  1  clears tx_ovf and rx_ovf
- spi_go  out  1  to engine go
- spi_data  out  16  to engine data_i
- spi_state  in  1  from engine state (1 = busy)
- spi_rx  in  8  from engine data_o

Behaviour:
- Reset (async, rst=1): both FIFOs empty, pointers 0.
  - spi_go=0, spi_data=16'h0000, tx_ovf=0, rx_ovf=0, FSM=IDLE.
  - cmd_full=0, cmd_level=0, rd_empty=1, busy=0.
- FIFOs: synchronous, registered pointers with an extra wrap bit.
  - Full when pointers differ only in the MSB; empty when pointers are equal.
  - Simultaneous push and pop on a non-empty, non-full FIFO: level unchanged, both operations take effect.
  - Push to a full TX FIFO is dropped and sets tx_ovf.
  - rd_data updates the cycle after a pop.
- FSM states:
  - IDLE:
    - Stay while the TX FIFO is empty or spi_state=1.
    - If the head is a data command (bit15=0) and the RX FIFO is full, stall in IDLE; commands are never dropped.
    - Otherwise load spi_data <= head, pop TX, go to ISSUE.
  - ISSUE: spi_go=1 for exactly one cycle; go to WAIT_BUSY.
  - WAIT_BUSY:
    - spi_go=0; wait for spi_state=1, then go to WAIT_DONE.
    - If spi_state is still 0 after 4 cycles, return to IDLE without an RX push. This covers an engine held in reset.
  - WAIT_DONE: wait for spi_state=0, then go to CAPTURE.
  - CAPTURE:
    - If spi_data[15]=0, push spi_rx into the RX FIFO.
    - Go to IDLE.
    - spi_data remains unchanged until the next load.
- spi_data must remain stable from the ISSUE cycle through CAPTURE, because the engine indexes data_i bit-by-bit during the transfer.
- Command issue rate: at most one command per 4 + transfer cycles. Back-to-back commands leave at least one idle cycle with spi_go=0 between them, so the engine drives its idle line levels.
- A data command with bit count 0 is still issued. The engine returns idle immediately, and the RX push of spi_rx still occurs.
- clr_err has priority below set events in the same cycle: the flag stays set.
- rst mid-transfer: all state is cleared immediately and spi_go drops. An in-flight result is lost.

Test Plan:
- Push 16'h0801, 16'h08A5 with a behavioural engine returning 8'h3C and 8'hC3 → exactly 2 go pulses; RX reads 3C then C3; rd_empty=1 afterwards; busy returns to 0.
- Push 16'h8000, 16'h0855, 16'h8001 → 3 go pulses; exactly one RX entry; spi_data shows 16'h8000/16'h0855/16'h8001 in order, each stable while spi_state=1.
- AW=2: push 5 words with the engine stalled (spi_state=1) → cmd_full after 4, fifth dropped, tx_ovf=1; clr_err clears it.
- AW=2: fill the RX FIFO (4 results, no reads), queue another data command → no go until one rd_req; then it issues and the result lands.
- Engine never asserts state after go → FSM returns to IDLE after 4 cycles, no RX push, next command proceeds.
- Assert rst during WAIT_DONE → next cycle spi_go=0, cmd_level=0, rd_empty=1, flags clear.
